// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage (CPU)
//   and an auxiliary master (AUX, e.g. loader or debug port). Each granted
//   access runs IDLE -> ACCESS -> DONE. Writes spend one ACCESS cycle. Reads
//   spend MEM_LATENCY ACCESS cycles. IDLE always separates two accesses.
//
// Parameters
//   MEM_LATENCY   cycles from address presentation to valid d_data_read (1..8)
//
// Ports
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           MEM stage request, held stable while stalled
//   cpu_rdata                       registered CPU load data
//   cpu_stall                       combinational pipeline freeze
//   aux_valid/we/addr/wdata         AUX request, held until aux_ready
//   aux_ready, aux_rvalid           one-cycle AUX completion (rvalid on reads only)
//   aux_rdata                       registered AUX read data
//   d_address, d_data_write         registered memory address / write data
//   d_write_enable                  registered write strobe, first ACCESS cycle only
//   d_data_read                     memory read data

module dmem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_valid,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic [31:0] d_address,
  output logic [31:0] d_data_write,
  output logic        d_write_enable,
  input  logic [31:0] d_data_read
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic       OWNER_CPU = 1'b0;
  localparam logic       OWNER_AUX = 1'b1;
  localparam logic [3:0] LAST_CNT  = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] d_address_q, d_address_d;
  logic [31:0] d_data_write_q, d_data_write_d;
  logic        d_write_enable_q, d_write_enable_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] aux_rdata_q, aux_rdata_d;

  logic        any_req;
  logic        grant_aux;
  logic        access_last;

  // Round-robin: AUX wins when alone, or on a tie when the CPU had the last grant.
  assign any_req     = cpu_req | aux_valid;
  assign grant_aux   = aux_valid & (~cpu_req | (last_grant_q == OWNER_CPU));
  assign access_last = we_q | (cnt_q == LAST_CNT);

  // State register and all datapath flops; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      owner_q          <= OWNER_CPU;
      last_grant_q     <= OWNER_AUX;
      cnt_q            <= 4'd0;
      we_q             <= 1'b0;
      d_address_q      <= 32'd0;
      d_data_write_q   <= 32'd0;
      d_write_enable_q <= 1'b0;
      cpu_rdata_q      <= 32'd0;
      aux_rdata_q      <= 32'd0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      cnt_q            <= cnt_d;
      we_q             <= we_d;
      d_address_q      <= d_address_d;
      d_data_write_q   <= d_data_write_d;
      d_write_enable_q <= d_write_enable_d;
      cpu_rdata_q      <= cpu_rdata_d;
      aux_rdata_q      <= aux_rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (access_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the winner on a grant, count read latency, capture read data.
  // The write strobe is loaded on the grant so it is high for the first ACCESS cycle only.
  always_comb begin
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    we_d             = we_q;
    d_address_d      = d_address_q;
    d_data_write_d   = d_data_write_q;
    d_write_enable_d = 1'b0;
    cpu_rdata_d      = cpu_rdata_q;
    aux_rdata_d      = aux_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d          = grant_aux;
          last_grant_d     = grant_aux;
          cnt_d            = 4'd0;
          we_d             = grant_aux ? aux_we    : cpu_we;
          d_address_d      = grant_aux ? aux_addr  : cpu_addr;
          d_data_write_d   = grant_aux ? aux_wdata : cpu_wdata;
          d_write_enable_d = grant_aux ? aux_we    : cpu_we;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            if (owner_q == OWNER_AUX) aux_rdata_d = d_data_read;
            else                      cpu_rdata_d = d_data_read;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs. Completion is suppressed while reset is asserted, and the stall
  // simply follows cpu_req then.
  always_comb begin
    cpu_stall  = cpu_req & (reset | ~((state_q == DONE) & (owner_q == OWNER_CPU)));
    aux_ready  = ~reset & (state_q == DONE) & (owner_q == OWNER_AUX);
    aux_rvalid = aux_ready & ~we_q;
  end

  assign d_address      = d_address_q;
  assign d_data_write   = d_data_write_q;
  assign d_write_enable = d_write_enable_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign aux_rdata      = aux_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed scoreboard bench for dmem_arbiter (MEM_LATENCY = 2). Per-port
//   driver processes replay queued transactions. Each driver holds a request
//   until it completes. The main sequence pushes hand-computed completions
//   (owner, cycle, data) into a scoreboard queue. A monitor pops that queue on
//   every completion the DUT presents. Spot checks on the memory-side
//   signals are made at chosen cycles.

module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        owner;
    logic        is_read;
    logic [31:0] data;
    int          cycle;
  } exp_t;

  localparam logic CPU = 1'b0;
  localparam logic AUX = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        aux_valid = 1'b0, aux_we = 1'b0;
  logic [31:0] aux_addr = '0, aux_wdata = '0;
  logic        aux_ready, aux_rvalid;
  logic [31:0] aux_rdata;
  logic [31:0] d_address, d_data_write, d_data_read;
  logic        d_write_enable;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  txn_t cpu_q[$];
  txn_t aux_q[$];
  exp_t exp_q[$];
  logic cpu_busy = 1'b0, aux_busy = 1'b0;
  logic cpu_done_seen = 1'b0, aux_done_seen = 1'b0;

  logic [31:0] mem [0:63] = '{0: 32'hDEADBEEF, default: 32'h0};

  dmem_arbiter #(.MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .aux_valid(aux_valid), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .d_address(d_address), .d_data_write(d_data_write),
    .d_write_enable(d_write_enable), .d_data_read(d_data_read)
  );

  // Clock and a free-running cycle index used to time expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Zero-wait-state memory array. The arbiter itself provides the read latency.
  always @(posedge clk) if (d_write_enable) mem[d_address[7:2]] <= d_data_write;
  assign d_data_read = mem[d_address[7:2]];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic tickUntil(input int target);
    while (cyc < target) tick();
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    if (port == AUX) aux_q.push_back(t);
    else             cpu_q.push_back(t);
  endtask

  task automatic expectDone(input logic owner, input logic is_read, input logic [31:0] data, input int cycle);
    exp_t e;
    e.owner = owner;
    e.is_read = is_read;
    e.data = data;
    e.cycle = cycle;
    exp_q.push_back(e);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || cpu_q.size() != 0 || aux_q.size() != 0 || cpu_busy || aux_busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_idle: %0d completions still outstanding after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Scoreboard pop: owner, completion cycle, rvalid flag and read data.
  task automatic scoreCompletion(input logic owner);
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL unexpected_completion: owner %0d at cycle %0d, nothing expected", owner, cyc);
    end else begin
      e = exp_q.pop_front();
      checkOutput("completion_owner", 32'(owner), 32'(e.owner));
      checkOutput("completion_cycle", 32'(cyc), 32'(e.cycle));
      if (owner == AUX) checkOutput("aux_rvalid", 32'(aux_rvalid), 32'(e.is_read));
      if (e.is_read && owner == AUX) checkOutput("aux_rdata", aux_rdata, e.data);
      if (e.is_read && owner == CPU) checkOutput("cpu_rdata", cpu_rdata, e.data);
    end
  endtask

  // Monitor: a CPU completion is a held request with stall released.
  // An AUX completion is aux_ready.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_req && !cpu_stall) scoreCompletion(CPU);
      if (aux_ready) scoreCompletion(AUX);
      else if (aux_rvalid) checkOutput("aux_rvalid_without_ready", 32'(aux_rvalid), 32'd0);
    end
  end

  // CPU driver: holds each request until its completion, then presents the next.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (cpu_busy && cpu_done_seen) begin
        cpu_busy = 1'b0;
        cpu_req = 1'b0;
      end
      cpu_done_seen = 1'b0;
      if (!cpu_busy && cpu_q.size() > 0) begin
        t = cpu_q.pop_front();
        cpu_req = 1'b1;
        cpu_we = t.we;
        cpu_addr = t.addr;
        cpu_wdata = t.wdata;
        cpu_busy = 1'b1;
      end
      @(negedge clk);
      if (cpu_busy && cpu_req && !cpu_stall && !reset) cpu_done_seen = 1'b1;
    end
  end

  // AUX driver: same handshake, completion is aux_ready.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (aux_busy && aux_done_seen) begin
        aux_busy = 1'b0;
        aux_valid = 1'b0;
      end
      aux_done_seen = 1'b0;
      if (!aux_busy && aux_q.size() > 0) begin
        t = aux_q.pop_front();
        aux_valid = 1'b1;
        aux_we = t.we;
        aux_addr = t.addr;
        aux_wdata = t.wdata;
        aux_busy = 1'b1;
      end
      @(negedge clk);
      if (aux_busy && aux_ready) aux_done_seen = 1'b1;
    end
  end

  initial begin
    int t0;

    // Reset values.
    repeat (3) tick();
    checkOutput("reset_d_address", d_address, 32'h0);
    checkOutput("reset_d_we", 32'(d_write_enable), 32'h0);
    checkOutput("reset_aux_ready", 32'(aux_ready), 32'h0);
    checkOutput("reset_cpu_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    tick();

    // CPU read of 0x100 returning 0xDEADBEEF.
    t0 = cyc + 1;
    applyStimulus(CPU, 1'b0, 32'h100, 32'h0);
    expectDone(CPU, 1'b1, 32'hDEADBEEF, t0 + 3);
    tickUntil(t0);
    checkOutput("rd_stall_T", 32'(cpu_stall), 32'h1);
    tickUntil(t0 + 1);
    checkOutput("rd_addr_T1", d_address, 32'h100);
    checkOutput("rd_stall_T1", 32'(cpu_stall), 32'h1);
    tickUntil(t0 + 2);
    checkOutput("rd_addr_T2", d_address, 32'h100);
    checkOutput("rd_stall_T2", 32'(cpu_stall), 32'h1);
    tickUntil(t0 + 3);
    checkOutput("rd_stall_T3", 32'(cpu_stall), 32'h0);
    waitIdle(20);

    // CPU store of 0x12345678 to 0x40.
    t0 = cyc + 1;
    applyStimulus(CPU, 1'b1, 32'h40, 32'h12345678);
    expectDone(CPU, 1'b0, 32'h0, t0 + 2);
    tickUntil(t0 + 1);
    checkOutput("st_we_T1", 32'(d_write_enable), 32'h1);
    checkOutput("st_wdata_T1", d_data_write, 32'h12345678);
    checkOutput("st_addr_T1", d_address, 32'h40);
    tickUntil(t0 + 2);
    checkOutput("st_we_T2", 32'(d_write_enable), 32'h0);
    checkOutput("st_stall_T2", 32'(cpu_stall), 32'h0);
    waitIdle(20);

    // Tie straight out of reset: the CPU wins, then the AUX read follows.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    t0 = cyc + 1;
    applyStimulus(CPU, 1'b0, 32'h100, 32'h0);
    applyStimulus(AUX, 1'b0, 32'h40, 32'h0);
    expectDone(CPU, 1'b1, 32'hDEADBEEF, t0 + 3);
    expectDone(AUX, 1'b1, 32'h12345678, t0 + 7);
    tickUntil(t0 + 5);
    checkOutput("tie_aux_addr_T5", d_address, 32'h40);
    tickUntil(t0 + 6);
    checkOutput("tie_ready_T6", 32'(aux_ready), 32'h0);
    tickUntil(t0 + 7);
    checkOutput("tie_ready_T7", 32'(aux_ready), 32'h1);
    checkOutput("tie_rvalid_T7", 32'(aux_rvalid), 32'h1);
    tickUntil(t0 + 8);
    checkOutput("tie_ready_T8", 32'(aux_ready), 32'h0);
    checkOutput("tie_rvalid_T8", 32'(aux_rvalid), 32'h0);
    waitIdle(30);

    // Sustained contention: grants alternate CPU, AUX, CPU, AUX, CPU.
    t0 = cyc + 1;
    applyStimulus(CPU, 1'b1, 32'h80, 32'hA5A5A5A5);
    applyStimulus(CPU, 1'b0, 32'h100, 32'h0);
    applyStimulus(CPU, 1'b0, 32'hC0, 32'h0);
    applyStimulus(AUX, 1'b0, 32'h80, 32'h0);
    applyStimulus(AUX, 1'b1, 32'hC0, 32'h0BADF00D);
    expectDone(CPU, 1'b0, 32'h0, t0 + 2);
    expectDone(AUX, 1'b1, 32'hA5A5A5A5, t0 + 6);
    expectDone(CPU, 1'b1, 32'hDEADBEEF, t0 + 10);
    expectDone(AUX, 1'b0, 32'h0, t0 + 13);
    expectDone(CPU, 1'b1, 32'h0BADF00D, t0 + 17);
    waitIdle(40);

    // AUX write with the CPU idle.
    t0 = cyc + 1;
    applyStimulus(AUX, 1'b1, 32'h20, 32'h55AA55AA);
    expectDone(AUX, 1'b0, 32'h0, t0 + 2);
    tickUntil(t0 + 1);
    checkOutput("auxw_we_T1", 32'(d_write_enable), 32'h1);
    checkOutput("auxw_wdata_T1", d_data_write, 32'h55AA55AA);
    tickUntil(t0 + 2);
    checkOutput("auxw_ready_T2", 32'(aux_ready), 32'h1);
    checkOutput("auxw_stall_T2", 32'(cpu_stall), 32'h0);
    waitIdle(20);

    // Reset during an AUX read: no completion, reset values, then the CPU wins the tie.
    t0 = cyc + 1;
    applyStimulus(AUX, 1'b0, 32'h80, 32'h0);
    expectDone(CPU, 1'b1, 32'hDEADBEEF, t0 + 6);
    expectDone(AUX, 1'b1, 32'hA5A5A5A5, t0 + 10);
    tickUntil(t0);
    applyStimulus(CPU, 1'b0, 32'h100, 32'h0);
    tickUntil(t0 + 1);
    reset = 1'b1;
    tickUntil(t0 + 2);
    checkOutput("rst_d_address", d_address, 32'h0);
    checkOutput("rst_d_we", 32'(d_write_enable), 32'h0);
    checkOutput("rst_aux_ready", 32'(aux_ready), 32'h0);
    checkOutput("rst_aux_rdata", aux_rdata, 32'h0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
    checkOutput("rst_stall_follows_req", 32'(cpu_stall), 32'(cpu_req));
    tickUntil(t0 + 3);
    reset = 1'b0;
    waitIdle(30);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline's MEM stage (CPU port) and an auxiliary master such as a loader or debug port (AUX port). It sequences each access over a fixed memory latency, drives the memory-side address, write-data and write-enable outputs, and stalls the pipeline until the CPU access completes. It sits between the MEM stage outputs and the data memory.

## Interface
- MEM_LATENCY, default 2: cycles from address presentation to read-data valid on d_data_read; legal range 1..8.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  MEM stage holds a load or store
- cpu_we  in  1  CPU access is a store
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU store data, already lane-shifted by MEM
- cpu_rdata  out  32  CPU load data, registered
- cpu_stall  out  1  freeze pipeline
- aux_valid  in  1  AUX request pending
- aux_we  in  1  AUX access is a write
- aux_addr  in  32  AUX address
- aux_wdata  in  32  AUX write data
- aux_ready  out  1  one-cycle completion pulse
- aux_rvalid  out  1  aux_rdata valid, read completions only
- aux_rdata  out  32  AUX read data, registered
- d_address  out  32  memory address
- d_data_write  out  32  memory write data
- d_write_enable  out  1  memory write strobe
- d_data_read  in  32  memory read data

## Operation
- FSM states are IDLE, ACCESS and DONE. Registers are owner (CPU/AUX), last_grant, cnt (4 bits) and a latched we bit.
- IDLE:
  - With no request, stay in IDLE.
  - With one requester, grant it.
  - With both requesting, grant the port that is not last_grant (round-robin).
  - On a grant, register d_address, d_data_write and we from the winner; set owner and last_grant; clear cnt; go to ACCESS.
- ACCESS:
  - d_write_enable = we for the first ACCESS cycle only, 0 otherwise.
  - A write goes to DONE after one ACCESS cycle.
  - A read increments cnt each cycle. When cnt == MEM_LATENCY-1, capture d_data_read into the owner's rdata register and go to DONE.
- DONE:
  - Signal completion to the owner for one cycle, then go to IDLE.
  - CPU owner: cpu_stall deasserts.
  - AUX owner: aux_ready=1, plus aux_rvalid=1 if the access was a read.
- cpu_stall = cpu_req && !(state==DONE && owner==CPU). This is combinational.
- The AUX port must hold aux_valid and its fields stable until aux_ready. The CPU fields are stable while stalled.
- cpu_req dropping mid-access (flush): the access still completes, and the CPU read result is discarded by the pipeline.
- A request arriving during ACCESS or DONE waits. It is evaluated in the next IDLE cycle.
- d_address and d_data_write hold their last values while idle. cpu_rdata and aux_rdata hold until the next read by their owner.
- Reset:
  - Values: state=IDLE; last_grant=AUX, so the CPU wins the first tie; d_address=0, d_data_write=0, d_write_enable=0; cpu_rdata=0, aux_rdata=0; aux_ready=0, aux_rvalid=0.
  - cpu_stall follows cpu_req during reset.
  - Reset mid-access aborts it. There is no completion pulse, and d_write_enable is 0 from the next cycle.

## Timing
- A request is visible in IDLE at cycle T. The grant is registered at the end of T.
- Read: d_address is valid T+1..T+MEM_LATENCY. d_data_read is sampled at the end of T+MEM_LATENCY. DONE/completion is at T+MEM_LATENCY+1.
- Write: d_write_enable is high at T+1 only. DONE is at T+2.
- cpu_stall is high from T through the cycle before DONE. The pipeline advances at the end of the DONE cycle.
- Throughput: one access per MEM_LATENCY+2 cycles for reads and 3 cycles for writes. IDLE is always re-entered for one cycle between accesses.
- aux_ready and aux_rvalid are exactly one cycle wide.

## Test plan
- CPU read, MEM_LATENCY=2:
  - Stimulus: cpu_req=1, addr 0x100 at T; the memory model returns 0xDEADBEEF.
  - Response: d_address=0x100 at T+1..T+2; cpu_stall=1 at T..T+2; cpu_stall=0 at T+3 with cpu_rdata=0xDEADBEEF.
- CPU store:
  - Stimulus: addr 0x40, wdata 0x12345678.
  - Response: d_write_enable=1 only at T+1 with d_data_write=0x12345678; cpu_stall=0 at T+2.
- Tie with both reads, MEM_LATENCY=2:
  - Stimulus: both requesting at T, out of reset.
  - Response: CPU completes at T+3; AUX is granted at T+4; aux_ready=aux_rvalid=1 at T+7 only.
- Sustained contention:
  - Stimulus: both keep requesting for 4 accesses.
  - Response: grant order is CPU, AUX, CPU, AUX.
- AUX write, CPU idle:
  - Response: aux_ready pulses at T+2; aux_rvalid stays 0; cpu_stall stays 0.
- Reset mid-access:
  - Stimulus: reset at T+1 of an AUX read.
  - Response: no aux_ready; outputs at reset values next cycle; after release, a tie grants the CPU first.
